// File: rtl/ex_control_stage.sv
// ID/EX control pipeline stage: valid/ready handshake over a two-entry skid buffer,
// with flush for branch redirects and a saturating back-pressure counter.
module ex_control_stage #(
   parameter int ALU_OP_WIDTH    = 7,
   parameter int ALU_FUNC3_WIDTH = 3,
   parameter int ALU_FUNC7_WIDTH = 7,
   parameter int CNT_WIDTH       = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic                       alu_src_in,
   input  logic [ALU_OP_WIDTH-1:0]    alu_op_in,
   input  logic [ALU_FUNC3_WIDTH-1:0] alu_func3_in,
   input  logic [ALU_FUNC7_WIDTH-1:0] alu_func7_in,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic                       alu_src_out,
   output logic [ALU_OP_WIDTH-1:0]    alu_op_out,
   output logic [ALU_FUNC3_WIDTH-1:0] alu_func3_out,
   output logic [ALU_FUNC7_WIDTH-1:0] alu_func7_out,
   output logic [CNT_WIDTH-1:0]       stall_count
);

   localparam int PW = 1 + ALU_OP_WIDTH + ALU_FUNC3_WIDTH + ALU_FUNC7_WIDTH;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_BUSY  = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [PW-1:0]        main_q, main_d;
   logic [PW-1:0]        skid_q, skid_d;
   logic                 in_ready_q, in_ready_d;
   logic [CNT_WIDTH-1:0] stall_count_q, stall_count_d;
   logic [PW-1:0]        in_bundle;
   logic                 in_fire;
   logic                 out_fire;

   assign in_bundle = {alu_src_in, alu_op_in, alu_func3_in, alu_func7_in};
   assign out_valid = (state_q != ST_EMPTY);
   assign in_ready  = in_ready_q;
   assign in_fire   = in_valid & in_ready_q;
   assign out_fire  = out_valid & out_ready;

   assign {alu_src_out, alu_op_out, alu_func3_out, alu_func7_out} = main_q;
   assign stall_count = stall_count_q;

   // Flush outranks the handshake; any bundle offered in the flush cycle is dropped.
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
         state_d = ST_EMPTY;
         main_d  = '0;
         skid_d  = '0;
      end else begin
         unique case (state_q)
            ST_EMPTY: begin
               if (in_fire) begin
                  main_d  = in_bundle;
                  state_d = ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (in_fire && out_fire) begin
                  main_d = in_bundle;
               end else if (in_fire) begin
                  skid_d  = in_bundle;
                  state_d = ST_FULL;
               end else if (out_fire) begin
                  state_d = ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (out_fire) begin
                  main_d  = skid_q;
                  state_d = ST_BUSY;
               end
            end
            default: begin
               state_d = ST_EMPTY;
            end
         endcase
      end
   end

   // Registering ready from the next state keeps out_ready off the in_ready path.
   always_comb begin
      in_ready_d    = (state_d != ST_FULL);
      stall_count_d = stall_count_q;
      if (out_valid && !out_ready && (stall_count_q != {CNT_WIDTH{1'b1}})) begin
         stall_count_d = stall_count_q + CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q       <= ST_EMPTY;
         main_q        <= '0;
         skid_q        <= '0;
         in_ready_q    <= 1'b1;
         stall_count_q <= '0;
      end else begin
         state_q       <= state_d;
         main_q        <= main_d;
         skid_q        <= skid_d;
         in_ready_q    <= in_ready_d;
         stall_count_q <= stall_count_d;
      end
   end

endmodule

// File: tb/tb_ex_control_stage.sv
// Directed self-checking bench for ex_control_stage: reset, streaming, skid,
// flush, counter saturation (second instance with CNT_WIDTH=2) and mid-run reset.
module tb_ex_control_stage;

   logic        clk;
   logic        reset;
   logic        flush;
   logic        in_valid;
   logic        alu_src_in;
   logic [6:0]  alu_op_in;
   logic [2:0]  alu_func3_in;
   logic [6:0]  alu_func7_in;
   logic        out_ready;

   logic        in_ready;
   logic        out_valid;
   logic        alu_src_out;
   logic [6:0]  alu_op_out;
   logic [2:0]  alu_func3_out;
   logic [6:0]  alu_func7_out;
   logic [15:0] stall_count;

   logic        sat_in_ready;
   logic        sat_out_valid;
   logic        sat_alu_src_out;
   logic [6:0]  sat_alu_op_out;
   logic [2:0]  sat_alu_func3_out;
   logic [6:0]  sat_alu_func7_out;
   logic [1:0]  sat_stall_count;

   int errors = 0;
   int checks = 0;

   ex_control_stage dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .alu_src_in(alu_src_in), .alu_op_in(alu_op_in),
      .alu_func3_in(alu_func3_in), .alu_func7_in(alu_func7_in),
      .out_valid(out_valid), .out_ready(out_ready),
      .alu_src_out(alu_src_out), .alu_op_out(alu_op_out),
      .alu_func3_out(alu_func3_out), .alu_func7_out(alu_func7_out),
      .stall_count(stall_count)
   );

   ex_control_stage #(.CNT_WIDTH(2)) dut_sat (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(sat_in_ready),
      .alu_src_in(alu_src_in), .alu_op_in(alu_op_in),
      .alu_func3_in(alu_func3_in), .alu_func7_in(alu_func7_in),
      .out_valid(sat_out_valid), .out_ready(out_ready),
      .alu_src_out(sat_alu_src_out), .alu_op_out(sat_alu_op_out),
      .alu_func3_out(sat_alu_func3_out), .alu_func7_out(sat_alu_func7_out),
      .stall_count(sat_stall_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic applyStimulus(input logic v, input logic [6:0] op, input logic [2:0] f3,
                                input logic [6:0] f7, input logic src,
                                input logic ordy, input logic fl);
      in_valid     = v;
      alu_op_in    = op;
      alu_func3_in = f3;
      alu_func7_in = f7;
      alu_src_in   = src;
      out_ready    = ordy;
      flush        = fl;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   initial begin
      reset = 1'b0;
      applyStimulus(1'b0, 7'h0, 3'h0, 7'h0, 1'b0, 1'b0, 1'b0);

      // Reset held two cycles with random inputs
      for (int i = 0; i < 2; i++) begin
         applyStimulus(1'($urandom), 7'($urandom), 3'($urandom), 7'($urandom),
                       1'($urandom), 1'($urandom), 1'($urandom));
         tick();
      end
      checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
      checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
      checkOutput("reset_alu_op", 32'(alu_op_out), 32'd0);
      checkOutput("reset_stall_count", 32'(stall_count), 32'd0);
      checkOutput("reset_sat_stall", 32'(sat_stall_count), 32'd0);

      reset = 1'b1;
      applyStimulus(1'b0, 7'h0, 3'h0, 7'h0, 1'b0, 1'b1, 1'b0);
      tick();

      // Streaming at full rate
      applyStimulus(1'b1, 7'h33, 3'h1, 7'h20, 1'b0, 1'b1, 1'b0);
      tick();
      checkOutput("stream0_valid", 32'(out_valid), 32'd1);
      checkOutput("stream0_op", 32'(alu_op_out), 32'h33);
      checkOutput("stream0_f3", 32'(alu_func3_out), 32'h1);
      checkOutput("stream0_f7", 32'(alu_func7_out), 32'h20);
      checkOutput("stream0_in_ready", 32'(in_ready), 32'd1);
      applyStimulus(1'b1, 7'h13, 3'h2, 7'h00, 1'b1, 1'b1, 1'b0);
      tick();
      checkOutput("stream1_op", 32'(alu_op_out), 32'h13);
      checkOutput("stream1_src", 32'(alu_src_out), 32'd1);
      checkOutput("stream1_in_ready", 32'(in_ready), 32'd1);
      applyStimulus(1'b1, 7'h03, 3'h4, 7'h00, 1'b0, 1'b1, 1'b0);
      tick();
      checkOutput("stream2_op", 32'(alu_op_out), 32'h03);
      checkOutput("stream2_in_ready", 32'(in_ready), 32'd1);
      applyStimulus(1'b0, 7'h00, 3'h0, 7'h00, 1'b0, 1'b1, 1'b0);
      tick();
      checkOutput("stream_drain_valid", 32'(out_valid), 32'd0);
      checkOutput("stream_stall", 32'(stall_count), 32'd0);

      // Skid buffer: A, B under back-pressure, C held upstream
      applyStimulus(1'b1, 7'h33, 3'h0, 7'h20, 1'b0, 1'b0, 1'b0);
      tick();
      checkOutput("skidA_valid", 32'(out_valid), 32'd1);
      checkOutput("skidA_op", 32'(alu_op_out), 32'h33);
      checkOutput("skidA_in_ready", 32'(in_ready), 32'd1);
      applyStimulus(1'b1, 7'h13, 3'h5, 7'h00, 1'b1, 1'b0, 1'b0);
      tick();
      checkOutput("skidB_in_ready", 32'(in_ready), 32'd0);
      checkOutput("skidB_hold_op", 32'(alu_op_out), 32'h33);
      checkOutput("skidB_stall", 32'(stall_count), 32'd1);
      applyStimulus(1'b1, 7'h03, 3'h0, 7'h00, 1'b0, 1'b0, 1'b0);
      tick();
      checkOutput("skidC_held_in_ready", 32'(in_ready), 32'd0);
      checkOutput("skidC_held_op", 32'(alu_op_out), 32'h33);
      checkOutput("skidC_held_f3", 32'(alu_func3_out), 32'h0);
      checkOutput("skid_stall_release", 32'(stall_count), 32'd2);
      applyStimulus(1'b1, 7'h03, 3'h0, 7'h00, 1'b0, 1'b1, 1'b0);
      tick();
      checkOutput("skid_outB_op", 32'(alu_op_out), 32'h13);
      checkOutput("skid_outB_f3", 32'(alu_func3_out), 32'h5);
      checkOutput("skid_outB_in_ready", 32'(in_ready), 32'd1);
      checkOutput("skid_outB_stall", 32'(stall_count), 32'd2);
      tick();
      checkOutput("skid_outC_valid", 32'(out_valid), 32'd1);
      checkOutput("skid_outC_op", 32'(alu_op_out), 32'h03);
      applyStimulus(1'b0, 7'h00, 3'h0, 7'h00, 1'b0, 1'b1, 1'b0);
      tick();
      checkOutput("skid_drain_valid", 32'(out_valid), 32'd0);

      // Flush in FULL with a bundle offered
      applyStimulus(1'b1, 7'h33, 3'h0, 7'h00, 1'b0, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b1, 7'h13, 3'h0, 7'h00, 1'b0, 1'b0, 1'b0);
      tick();
      checkOutput("pre_flush_in_ready", 32'(in_ready), 32'd0);
      checkOutput("pre_flush_stall", 32'(stall_count), 32'd3);
      applyStimulus(1'b1, 7'h63, 3'h0, 7'h00, 1'b0, 1'b1, 1'b1);
      tick();
      checkOutput("flush_full_valid", 32'(out_valid), 32'd0);
      checkOutput("flush_full_in_ready", 32'(in_ready), 32'd1);
      checkOutput("flush_full_op", 32'(alu_op_out), 32'd0);
      checkOutput("flush_full_stall", 32'(stall_count), 32'd3);
      applyStimulus(1'b0, 7'h00, 3'h0, 7'h00, 1'b0, 1'b1, 1'b0);
      tick();
      checkOutput("flush_full_no63", 32'(out_valid), 32'd0);

      // Flush in BUSY while in_ready=1: offered bundle must still be dropped
      applyStimulus(1'b1, 7'h23, 3'h0, 7'h00, 1'b0, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b1, 7'h63, 3'h0, 7'h00, 1'b0, 1'b1, 1'b1);
      tick();
      checkOutput("flush_busy_valid", 32'(out_valid), 32'd0);
      checkOutput("flush_busy_op", 32'(alu_op_out), 32'd0);
      applyStimulus(1'b0, 7'h00, 3'h0, 7'h00, 1'b0, 1'b1, 1'b0);
      tick();
      checkOutput("flush_busy_no63", 32'(out_valid), 32'd0);

      // Saturation: fresh reset, one bundle held under back-pressure
      reset = 1'b0;
      tick();
      reset = 1'b1;
      applyStimulus(1'b1, 7'h23, 3'h2, 7'h00, 1'b0, 1'b0, 1'b0);
      tick();
      checkOutput("sat_start", 32'(sat_stall_count), 32'd0);
      applyStimulus(1'b0, 7'h00, 3'h0, 7'h00, 1'b0, 1'b0, 1'b0);
      for (int i = 1; i <= 5; i++) begin
         tick();
         checkOutput($sformatf("sat_cnt2_%0d", i), 32'(sat_stall_count), (i < 3) ? i : 3);
         checkOutput($sformatf("sat_cnt16_%0d", i), 32'(stall_count), i);
         checkOutput($sformatf("sat_hold_op_%0d", i), 32'(alu_op_out), 32'h23);
      end
      checkOutput("sat_hold_valid", 32'(out_valid), 32'd1);

      // Reset mid-operation in FULL
      applyStimulus(1'b1, 7'h33, 3'h0, 7'h00, 1'b0, 1'b0, 1'b0);
      tick();
      checkOutput("pre_reset_in_ready", 32'(in_ready), 32'd0);
      reset = 1'b0;
      applyStimulus(1'b0, 7'h00, 3'h0, 7'h00, 1'b0, 1'b0, 1'b0);
      tick();
      checkOutput("midreset_valid", 32'(out_valid), 32'd0);
      checkOutput("midreset_in_ready", 32'(in_ready), 32'd1);
      checkOutput("midreset_stall", 32'(stall_count), 32'd0);
      checkOutput("midreset_op", 32'(alu_op_out), 32'd0);
      reset = 1'b1;
      applyStimulus(1'b1, 7'h13, 3'h6, 7'h20, 1'b1, 1'b1, 1'b0);
      tick();
      checkOutput("post_reset_valid", 32'(out_valid), 32'd1);
      checkOutput("post_reset_op", 32'(alu_op_out), 32'h13);
      checkOutput("post_reset_f7", 32'(alu_func7_out), 32'h20);
      applyStimulus(1'b0, 7'h00, 3'h0, 7'h00, 1'b0, 1'b1, 1'b0);
      tick();
      checkOutput("post_reset_drain", 32'(out_valid), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ex_control_stage.md
# ex_control_stage

Parametrised ID/EX control pipeline stage carrying the ALU control bundle (alu_src, alu_op, func3, func7) from decode into execute. Adds a valid/ready handshake, a two-entry skid buffer so that `in_ready` is a registered signal, a pipeline flush for branch redirects, and a saturating back-pressure counter for performance analysis. It sits between the decode stage and the ALU, replacing a plain always-load control register.

## Interface

Parameters:
- ALU_OP_WIDTH, 7, width of alu_op
- ALU_FUNC3_WIDTH, 3, width of func3
- ALU_FUNC7_WIDTH, 7, width of func7
- CNT_WIDTH, 16, width of stall_count (≥1)

Ports:
- clk  input  1  single clock; all state updates on posedge
- reset  input  1  synchronous, active-low; state is cleared on a posedge clk where reset==0
- flush  input  1  kills all held entries (branch mispredict or exception)
- in_valid  input  1  upstream bundle valid
- in_ready  output  1  stage can accept; registered
- alu_src_in  input  1  operand-2 select (immediate vs register)
- alu_op_in  input  ALU_OP_WIDTH  opcode class
- alu_func3_in  input  ALU_FUNC3_WIDTH  func3
- alu_func7_in  input  ALU_FUNC7_WIDTH  func7
- out_valid  output  1  downstream bundle valid
- out_ready  input  1  execute stage accepts
- alu_src_out, alu_op_out, alu_func3_out, alu_func7_out  output  matching widths  held bundle
- stall_count  output  CNT_WIDTH  saturating count of back-pressured cycles

## Operation

- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Storage: main register (drives outputs) and skid register, each holding a full bundle.
- States:
  - EMPTY: out_valid=0, in_ready=1.
  - BUSY: main valid, skid empty, in_ready=1.
  - FULL: both valid, in_ready=0.
- Transitions (no reset, no flush):
  - EMPTY: in_fire → main<=in, BUSY; else stay.
  - BUSY: in_fire & out_fire → main<=in, BUSY. in_fire only → skid<=in, FULL. out_fire only → EMPTY. Neither → stay.
  - FULL: out_fire → main<=skid, BUSY. Otherwise stay. No input is accepted because in_ready=0.
- Priority: reset > flush > normal.
- Flush: next state EMPTY, and both payload registers are cleared to 0. An in_fire in the flush cycle is dropped. An out_fire in the flush cycle still counts as consumed by downstream.
- Reset: state EMPTY, all payloads 0, stall_count 0.
- After draining to EMPTY without a flush, payload outputs hold their last value. The bench checks payload only when out_valid=1.
- stall_count: +1 on each cycle with out_valid & !out_ready. Saturates at 2^CNT_WIDTH−1 with no wrap. Cleared by reset only; flush does not affect it.
- Ordering: strictly FIFO, with no loss and no duplication.

## Timing

- Reset values: out_valid=0, in_ready=1, all bundle outputs 0, stall_count 0.
- Latency: in_fire at cycle N → out_valid=1 with that bundle at cycle N+1.
- Throughput: one bundle per cycle while out_ready=1.
- in_ready is a flop output with no combinational path from out_ready. It deasserts the cycle after the entry into FULL and reasserts the cycle after the FULL→BUSY drain.
- Flush at cycle N → out_valid=0 and in_ready=1 at N+1.
- Back-pressure: out_valid and the bundle remain stable while out_ready=0.
- Reset in FULL or BUSY behaves identically to reset in EMPTY.

## Test plan

- Reset: hold reset=0 for 2 cycles with random inputs → out_valid=0, in_ready=1, alu_op_out=0, stall_count=0.
- Streaming: out_ready=1; in_valid on 3 consecutive cycles with alu_op 0x33, 0x13, 0x03 → each appears exactly one cycle later, and in_ready stays 1 throughout.
- Skid: out_ready=0; send A (op 0x33, func3 0) then B (op 0x13, func3 5) → in_ready=0 after B; C (op 0x03) is held upstream; then out_ready=1 → out sequence is A, B, C with no duplicates; stall_count=2 at release.
- Flush in FULL with in_valid=1 (op 0x63) in the same cycle → next cycle out_valid=0, in_ready=1, alu_op_out=0, and 0x63 never appears; stall_count is unchanged.
- Saturation with CNT_WIDTH=2: hold one valid bundle with out_ready=0 for 5 cycles → stall_count reads 1, 2, 3, 3, 3.
- Reset mid-operation in FULL → next cycle EMPTY, in_ready=1, stall_count=0; a subsequent in_fire emerges with 1-cycle latency.
